// File: rtl/adc128s022_pkg.sv
// Shared constants, types and helpers for the ADC128S022 serial-side model.
package adc128s022_pkg;
  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 12;
  localparam int ADDR_W   = 3;
  localparam int CNT_W    = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  // Edge numbers within a frame, counted from 1 after CS_N falls.
  localparam cnt_t FRAME_EDGES     = 5'd16;
  localparam cnt_t ADDR_RISE_FIRST = 5'd3;
  localparam cnt_t ADDR_RISE_LAST  = ADDR_RISE_FIRST + 5'd2;
  localparam cnt_t LOAD_FALL       = 5'd4;
  localparam cnt_t DATA_FALL_FIRST = 5'd5;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Pick channel `a` out of the flat per-channel sample bus.
  function automatic logic [SAMPLE_W-1:0] ch_sel(
    input logic [NUM_CH*SAMPLE_W-1:0] d,
    input logic [ADDR_W-1:0]          a
  );
    return d[a*SAMPLE_W +: SAMPLE_W];
  endfunction
endpackage

// File: rtl/adc128s022_model_if.sv
// Board-side SPI pins of the ADC. master = controller, slave = this model.
interface adc128s022_model_if;
  logic SCLK;
  logic CS_N;
  logic DIN;
  logic DOUT;

  modport master (output SCLK, output CS_N, output DIN, input DOUT);
  modport slave  (input SCLK, input CS_N, input DIN, output DOUT);
endinterface

// File: rtl/adc128s022_model_spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with edge pulses taken
// from the last two synchronized samples.
module spi_in_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic              prev;

  // On reset the chain is preloaded with the current pin level so that
  // releasing reset never manufactures an edge (a held-low CS_N must not
  // look like a fresh frame start).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{d}};
      prev <= d;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise =  q & ~prev;
  assign fall = ~q &  prev;
endmodule

// File: rtl/adc128s022_model.sv
// ADC128S022 serial responder: decodes the channel address from DIN and
// shifts the previously addressed channel's sample out on DOUT, MSB first.
module adc128s022_model
  import adc128s022_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
  adc128s022_model_if.slave          spi,
  output logic                       busy,
  output logic                       frame_done,
  output logic [ADDR_W-1:0]          last_addr
);
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, din_q;
  logic sclk_lvl_unused, cs_lvl_unused, din_rise_unused, din_fall_unused;

  spi_in_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .d(spi.SCLK),
    .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst(rst), .d(spi.CS_N),
    .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall));
  spi_in_sync #(.STAGES(SYNC_STAGES)) u_din (
    .clk(clk), .rst(rst), .d(spi.DIN),
    .q(din_q), .rise(din_rise_unused), .fall(din_fall_unused));

  state_t                state_q, state_d;
  cnt_t                  rise_cnt, fall_cnt, rise_n, fall_n;
  logic [ADDR_W-1:0]     addr_shift, cur_addr;
  logic [SAMPLE_W-1:0]   shift;
  logic                  dout_bit, dout_q;
  logic                  active, frame_end;

  assign active    = (state_q == ACTIVE);
  assign rise_n    = rise_cnt + 5'd1;
  assign fall_n    = fall_cnt + 5'd1;
  assign frame_end = active & sclk_rise & (rise_n == FRAME_EDGES);

  // Next state: CS_N rise wins over a fall in the same sample.
  always_comb begin
    state_d = state_q;
    if (cs_fall) state_d = ACTIVE;
    if (cs_rise) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Edge counting, address capture, sample shift-out and frame commit.
  // A coincident rise 16 and CS_N rise completes the frame first; the
  // idle clear below only touches counters and the partial address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      addr_shift <= '0;
      cur_addr   <= '0;
      last_addr  <= '0;
      shift      <= '0;
      dout_bit   <= 1'b0;
      dout_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      dout_q     <= dout_bit;
      if (active && sclk_fall) begin
        fall_cnt <= fall_n;
        if (fall_n == LOAD_FALL) shift <= ch_sel(ch_data, cur_addr);
        if (fall_n >= DATA_FALL_FIRST) begin
          dout_bit <= shift[SAMPLE_W-1];
          shift    <= {shift[SAMPLE_W-2:0], 1'b0};
        end else begin
          dout_bit <= 1'b0;
        end
      end
      if (active && sclk_rise) begin
        rise_cnt <= rise_n;
        if (rise_n >= ADDR_RISE_FIRST && rise_n <= ADDR_RISE_LAST)
          addr_shift <= {addr_shift[ADDR_W-2:0], din_q};
        if (frame_end) begin
          cur_addr   <= addr_shift;
          last_addr  <= addr_shift;
          frame_done <= 1'b1;
          rise_cnt   <= '0;
          fall_cnt   <= '0;
        end
      end
      if (state_d == IDLE || cs_fall) begin
        rise_cnt   <= '0;
        fall_cnt   <= '0;
        addr_shift <= '0;
      end
      if (state_d == IDLE) dout_bit <= 1'b0;
    end
  end

  assign busy     = active;
  assign spi.DOUT = dout_q;
endmodule

// File: tb/tb_adc128s022_model.sv
// Randomized bench: a controller model drives frames, a reference model
// predicts each completed frame's sample/address, and an independent
// monitor reassembles DOUT and scores it at every frame_done.
module tb_adc128s022_model;
  localparam int HALF  = 6;
  localparam int SETUP = 6;

  typedef struct packed {
    logic [11:0] data;
    logic [2:0]  addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] ch_data;
  logic        busy, frame_done;
  logic [2:0]  last_addr;

  adc128s022_model_if ifc ();

  adc128s022_model #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .spi(ifc),
    .busy(busy), .frame_done(frame_done), .last_addr(last_addr));

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q[$];
  logic [11:0] ch_model[8];
  logic [2:0]  cur_model;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input logic [2:0] c, input logic [11:0] v);
    ch_model[c] = v;
    ch_data[c*12 +: 12] = v;
  endtask

  // One frame of nrise SCLK periods with CS_N already low. Expectation is
  // recorded at fall 4, when the converter samples the channel chosen by
  // the previous frame. Optional ch_data change and reset at given rises.
  task automatic frame(input logic [2:0] addr, input int nrise,
                       input int hook_rise, input logic [2:0] hook_ch,
                       input logic [11:0] hook_val, input int rst_rise);
    bit   completes = (nrise == 16) && (rst_rise == 0);
    exp_t e;
    for (int k = 1; k <= nrise; k++) begin
      tick(1);
      ifc.SCLK = 1'b0;
      ifc.DIN  = (k == 3) ? addr[2] : (k == 4) ? addr[1] :
                 (k == 5) ? addr[0] : 1'($urandom);
      if (k == 4 && completes) begin
        e.data = ch_model[cur_model];
        e.addr = addr;
        exp_q.push_back(e);
        cur_model = addr;
      end
      tick(HALF - 1);
      ifc.SCLK = 1'b1;
      if (k == hook_rise) set_ch(hook_ch, hook_val);
      if (k == rst_rise) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        cur_model = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_dout", int'(ifc.DOUT), 0);
        return;
      end
      tick(HALF - 1);
    end
  endtask

  task automatic cs_low();
    tick(1);
    ifc.CS_N = 1'b0;
    tick(SETUP);
    @(negedge clk);
    chk("busy_active", int'(busy), 1);
  endtask

  task automatic cs_high();
    tick(HALF);
    ifc.CS_N = 1'b1;
    tick(8);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_dout", int'(ifc.DOUT), 0);
  endtask

  task automatic run_frame(input logic [2:0] addr);
    cs_low();
    frame(addr, 16, 0, 3'd0, 12'd0, 0);
    cs_high();
  endtask

  // Monitor: reassembles the 12 data bits seen on SCLK rises 5..16 and
  // scores them, plus last_addr, against the next expectation at frame_done.
  int          rcnt = 0;
  int          pend_wait = 0;
  bit          pend = 0;
  logic        sclk_p = 1'b1;
  logic        fd_p = 1'b0;
  logic [11:0] word = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      rcnt = 0;
      pend = 0;
    end else begin
      if (ifc.CS_N) begin
        rcnt = 0;
      end else if (ifc.SCLK && !sclk_p) begin
        rcnt++;
        if (rcnt >= 5) word = {word[10:0], ifc.DOUT};
        if (rcnt == 16) begin
          rcnt = 0;
          pend = 1;
          pend_wait = 0;
        end
      end
      if (frame_done) begin
        if (fd_p) chk("frame_done_width", 2, 1);
        else if (!pend) chk("frame_done_unexpected", 1, 0);
        else if (exp_q.size() == 0) chk("frame_done_no_expect", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("frame_data", int'(word), int'(e.data));
          chk("frame_last_addr", int'(last_addr), int'(e.addr));
          pend = 0;
        end
      end else if (pend) begin
        pend_wait++;
        if (pend_wait > 10) begin
          chk("frame_done_timeout", 0, 1);
          pend = 0;
        end
      end
    end
    sclk_p = ifc.SCLK;
    fd_p   = frame_done;
  end

  initial begin
    rst      = 1'b1;
    ifc.CS_N = 1'b1;
    ifc.SCLK = 1'b1;
    ifc.DIN  = 1'b0;
    cur_model = 3'd0;
    for (int c = 0; c < 8; c++) set_ch(3'(c), 12'($urandom));
    tick(4);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_dout", int'(ifc.DOUT), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_last_addr", int'(last_addr), 0);

    // First frame returns ch0 (reset channel), second the channel chosen by the first.
    set_ch(3'd0, 12'hABC);
    run_frame(3'd3);
    set_ch(3'd3, 12'h5A5);
    run_frame(3'd7);

    // Abort after rise 8: address 5 discarded.
    cs_low();
    frame(3'd5, 8, 0, 3'd0, 12'd0, 0);
    cs_high();
    chk("abort_last_addr", int'(last_addr), 7);
    run_frame(3'd7);

    // Continuous mode: two frames with CS_N held low.
    cs_low();
    frame(3'd1, 16, 0, 3'd0, 12'd0, 0);
    frame(3'd2, 16, 0, 3'd0, 12'd0, 0);
    cs_high();

    // ch_data change after vs. before the fall-4 load (channel 2 is current).
    set_ch(3'd2, 12'h000);
    cs_low();
    frame(3'd2, 16, 4, 3'd2, 12'hFFF, 0);
    cs_high();
    set_ch(3'd2, 12'h000);
    cs_low();
    frame(3'd2, 16, 3, 3'd2, 12'hFFF, 0);
    cs_high();

    // Reset at rise 10, then a full frame from ch0.
    cs_low();
    frame(3'd4, 16, 0, 3'd0, 12'd0, 10);
    cs_high();
    chk("rst_last_addr", int'(last_addr), 0);
    run_frame(3'd6);

    // Random frames with random sample updates, some continuous.
    for (int i = 0; i < 8; i++) begin
      set_ch(3'($urandom_range(0, 7)), 12'($urandom));
      set_ch(cur_model, 12'($urandom));
      if (i % 3 == 2) begin
        cs_low();
        frame(3'($urandom_range(0, 7)), 16, 0, 3'd0, 12'd0, 0);
        frame(3'($urandom_range(0, 7)), 16, 0, 3'd0, 12'd0, 0);
        cs_high();
      end else begin
        run_frame(3'($urandom_range(0, 7)));
      end
    end

    tick(20);
    chk("expect_queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
